// File: rtl/rs232_rcv_if.sv
// Host-side bus of the RS-232 receiver: serial input, pop/clear strobes,
// data and status words, plus the receive FSM state for observation.
interface rs232_rcv_if;
  logic        rxd;
  logic        rd;
  logic        clr;
  logic [31:0] dout;
  logic [31:0] status;
  logic [2:0]  dbg_state;

  modport master (output rxd, rd, clr, input dout, status, dbg_state);
  modport slave  (input rxd, rd, clr, output dout, status, dbg_state);
endinterface

// File: rtl/rs232_rcv.sv
// 8N1 UART receiver with a mid-bit sampling FSM feeding a small byte FIFO
// and sticky overrun / framing-error flags.
module rs232_rcv #(
  parameter int DIV        = 217,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rs232_rcv_if.slave   bus
);

  // Host strobes: rd pops the head byte in the cycle it is high (ignored
  // when empty); clr clears ovr/ferr in the cycle it is high unless a new
  // error is raised in that same cycle. No ready/backpressure exists.

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [11:0] DIV_M1  = 12'(DIV - 1);
  localparam logic [11:0] HALF_M1 = 12'(DIV / 2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    WAITHI = 3'd4
  } state_t;

  state_t      state, state_d;
  logic [11:0] cnt, cnt_d;
  logic [2:0]  idx, idx_d;
  logic [7:0]  shreg, shreg_d;
  logic        push, set_ferr;
  logic        rx_meta, rxs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shreg <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    shreg_d  = shreg;
    push     = 1'b0;
    set_ferr = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
            cnt_d   = DIV_M1;
          end
        end else begin
          cnt_d = cnt - 12'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_d[idx] = rxs;
          cnt_d        = DIV_M1;
          if (idx == 3'd7) state_d = STOP;
          else             idx_d   = idx + 3'd1;
        end else begin
          cnt_d = cnt - 12'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rxs) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            set_ferr = 1'b1;
            state_d  = WAITHI;
          end
        end else begin
          cnt_d = cnt - 12'd1;
        end
      end
      WAITHI: begin
        // A break holds the line low; only its end re-arms start detection.
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full, pop, wr_en, set_ovr;
  logic                  ovr, ferr;

  // count never exceeds DEPTH, so its MSB alone marks full.
  assign full    = count[DEPTH_LOG2];
  assign pop     = bus.rd && (count != '0);
  assign wr_en   = push && (!full || pop);
  assign set_ovr = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovr  <= set_ovr  | (ovr  & ~bus.clr);
      ferr <= set_ferr | (ferr & ~bus.clr);
    end
  end

  logic rdy;
  assign rdy = (count != '0);

  assign bus.dout      = rdy ? {24'h0, mem[rptr]} : 32'h0;
  assign bus.status    = {23'h0, 5'(count), 1'b0, ferr, ovr, rdy};
  assign bus.dbg_state = state;

endmodule

// File: doc/rs232_rcv.md
RS232_RCV -- requirements
Module: rs232_rcv

Interface
REQ-001 Parameter DIV, default 217, clock cycles per bit (25 MHz / 115200 baud); legal range 8..4095.
REQ-002 Parameter DEPTH_LOG2, default 4, log2 of receive FIFO depth (16 entries).
REQ-003 clk  in  1  system clock, 25 MHz; all logic is on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 rxd  in  1  asynchronous serial line, idle high, 8N1 format, LSB first.
REQ-006 rd  in  1  one-cycle pop strobe (the data-register read).
REQ-007 clr  in  1  one-cycle strobe that clears the sticky error flags.
REQ-008 dout  out  32  {24'h0, FIFO head byte}; 32'h0 when the FIFO is empty.
REQ-009 status  out  32  {23'h0, count[4:0], 1'b0, ferr, ovr, rdy}.

Function
REQ-010 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs, 2 cycles late.
REQ-011 The FSM SHALL have the states IDLE, START, DATA, STOP and WAITHI; an 12-bit counter SHALL time the bits.
REQ-012 IDLE: when rxs=0, go to START and load counter=DIV/2-1 (integer division).
REQ-013 START: when counter=0, sample rxs; if 1, it is a false start and the FSM returns to IDLE; if 0, go to DATA, bit index=0, counter=DIV-1.
REQ-014 DATA: at each counter=0, shift rxs into bit[index] (LSB first) and reload counter=DIV-1; after index 7, go to STOP.
REQ-015 STOP: when counter=0, sample rxs; if 1, push the byte and go to IDLE; if 0, discard the byte, set ferr and go to WAITHI.
REQ-016 WAITHI: remain until rxs=1, then go to IDLE; a held-low line (break) SHALL produce exactly one ferr event.
REQ-017 FIFO: circular buffer of 2^DEPTH_LOG2 bytes, with read/write pointers of DEPTH_LOG2 bits (wrapping) and a count of DEPTH_LOG2+1 bits.
REQ-018 Push when full without a simultaneous pop: drop the byte, set ovr, leave the FIFO unchanged.
REQ-019 Push and pop in the same cycle: both take effect and count is unchanged, including when full; ovr is not set.
REQ-020 Pop (rd=1) when empty: no effect on pointers, count or flags.
REQ-021 dout SHALL be combinational from the head entry and pointer; after a pop, the next byte is visible in the following cycle.
REQ-022 rdy = (count != 0); count is reported in status[8:4], range 0..16.
REQ-023 ovr and ferr SHALL be sticky until clr=1 or reset; if a set and clr occur in the same cycle, the set wins.
REQ-024 Byte latency: the push occurs 2 (synchronizer) + DIV/2 + 9*DIV cycles after the start-bit falling edge at the rxd pin, ±1 cycle.

Reset
REQ-025 While rst_n=0 at a clock edge: FSM=IDLE, counter=0, index=0, pointers=0, count=0, ovr=0, ferr=0, and both synchronizer flops=1.
REQ-026 After reset, dout=32'h0 and status=32'h0 immediately.
REQ-027 Reset mid-frame SHALL abort the frame without pushing; the FIFO contents are lost.
REQ-028 FIFO storage needs no reset; a read of an empty FIFO still returns 0 per REQ-008.

Verification (DIV=16)
REQ-029 Send 8'hA5 with a good stop bit -> status=32'h11, dout=32'hA5; then rd=1 -> status=32'h0, dout=32'h0.
REQ-030 Send 17 bytes 8'h00..8'h10 with no reads -> count=16 and ovr=1 (status=32'h103); 16 reads return 00..0F in order; 8'h10 is lost.
REQ-031 Send 8'h3C with the stop bit driven 0, then hold the line low for 40 bit-times, then release -> ferr=1, count=0, no second ferr event; next byte 8'h55 is received correctly.
REQ-032 Drive a 4-cycle low glitch on rxd -> false start, FSM back to IDLE, count stays 0, no flags set.
REQ-033 With FIFO full, pulse rd in the exact cycle the 17th byte completes -> count stays 16, ovr=0, last entry is the 17th byte; also pulse clr while ovr=1 -> status bit1 clears the next cycle.
REQ-034 Assert rst_n=0 for 1 cycle during DATA bit 4 of a frame -> status=0; a frame started after release is received correctly.
